alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Operand-issue and writeback stage wrapped around the combinational `alu32` in the calculator CPU datapath. It accepts decoded ALU operations over a valid/ready handshake, reads a 32×32 register file, and drives registered `srca`/`srcb`/`alucontrol`/`shamt` into `alu32`. It captures `aluout`/`zero` into a result register, writes the register file, and presents the result downstream over a second valid/ready handshake. The two-stage pipeline (EX, WB) handles RAW hazards either by forwarding or by stalling.

## Interface
- `FWD_EN`, default 1: 1 forwards `aluout` to a dependent issue; 0 stalls issue one cycle instead.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  decoded op available.
- `in_ready`  out  1  stage accepts op this cycle (combinational).
- `in_rs1`, `in_rs2`, `in_rd`  in  5 each  register indices.
- `in_imm`  in  32  immediate.
- `in_useimm`  in  1  1 selects `in_imm` as srcb.
- `in_alucontrol`  in  4  ALU op code (0000 add, 1000 sub).
- `in_shamt`  in  5  shift amount, passed through.
- `srca`, `srcb`  out  32  registered operands to `alu32`.
- `alucontrol`  out  4  registered, to `alu32`.
- `shamt`  out  5  registered, to `alu32`.
- `aluout`  in  32  result from `alu32`.
- `zero`  in  1  zero flag from `alu32`.
- `res_valid`  out  1  result held in WB.
- `res_ready`  in  1  consumer takes result.
- `res_rd`  out  5  destination of held result.
- `res_data`  out  32  held result.
- `res_zero`  out  1  held zero flag.
- `dbg_raddr`  in  5  display read index.
- `dbg_rdata`  out  32  combinational register-file read (x0 = 0), no forwarding.

## Operation
- State: `ex_valid`, `ex_rd`, and the EX operand registers (which drive `srca`/`srcb`/`alucontrol`/`shamt`); `wb_valid` plus the `res_*` registers; register file x1..x31.
- `wb_free = !wb_valid | res_ready`. `ex_adv = ex_valid & wb_free`.
- Hazard: `ex_valid & ex_rd != 0 & (ex_rd == in_rs1 | (!in_useimm & ex_rd == in_rs2))`.
- `in_ready = !reset & (!ex_valid | ex_adv) & !(FWD_EN == 0 & hazard)`.
- Accept (`in_valid & in_ready`) at an edge loads the EX registers:
  - srca = rf[rs1].
  - srcb = useimm ? imm : rf[rs2].
  - Index 0 reads 0.
  - With FWD_EN=1, a hazard operand takes `aluout` instead of the register-file value.
  - Sets `ex_valid` = 1.
- No accept while `ex_adv`: `ex_valid` ← 0. EX operand outputs hold their last values.
- On `ex_adv` edge:
  - `res_data`/`res_zero`/`res_rd` ← `aluout`/`zero`/`ex_rd`; `wb_valid` ← 1.
  - rf[ex_rd] ← `aluout` if `ex_rd != 0`.
- `res_ready & wb_valid` with no `ex_adv`: `wb_valid` ← 0.
- `res_rd = 0` results are still delivered downstream but never written to the register file.
- Results leave in issue order. No drop, no duplication.

## Timing
- Reset, applied on any edge with `reset` high:
  - `ex_valid` = `wb_valid` = 0.
  - `srca`, `srcb`, `alucontrol`, `shamt` = 0.
  - `res_valid`, `res_rd`, `res_data`, `res_zero` = 0.
  - All registers cleared to 0.
  - `in_ready` = 0 while `reset` is high.
- Reset mid-operation discards in-flight ops with no register-file write.
- Latency: op accepted at edge N → `srca`/`srcb` valid after N → result and rf write at edge N+1 → `res_valid` = 1 after N+1.
- Throughput is 1 op/cycle with `res_ready` held high, including dependent back-to-back ops when FWD_EN=1.
- FWD_EN=0: a dependent op sees `in_ready` = 0 for exactly one cycle.
- Backpressure: `res_ready` = 0 holds WB. One further op fills EX, then `in_ready` = 0 until `res_ready` returns.
- Same-edge events:
  - WB drain and EX→WB advance: WB is reloaded and `res_valid` stays 1.
  - rf write and `dbg_raddr` read: `dbg_rdata` shows the new value from the next cycle.

## Test plan
- **Reset:** hold `reset` 2 cycles, then read `dbg_raddr` 0..31 → all 0. `in_ready` = 0 during reset, 1 the cycle after release.
- **Dependent chain, FWD_EN=1, `res_ready`=1:**
  - Issue `rs1=0, useimm, imm=5, rd=1, add`, then `rs1=1, rs2=1, rd=2, add` back-to-back.
  - Expect `res_data` 5 then 10 on consecutive cycles with no bubble. `dbg` x2 = 10.
- **Same chain, FWD_EN=0:** `in_ready` low exactly one cycle before the second op. Results 5, 10.
- **Subtract and zero flag:**
  - With x1=3, x2=5: `sub rd=3` (x1−x2) → `res_data` = 0xFFFFFFFE, `res_zero` = 0.
  - `sub` x1−x1 → `res_data` = 0, `res_zero` = 1.
- **Backpressure:**
  - `res_ready` = 0; offer 3 independent imm ops (1, 2, 3).
  - Two ops accepted, then `in_ready` = 0.
  - Release `res_ready` → results 1, 2, 3 in order, no loss.
- **x0 and reset mid-flight:**
  - `imm=7, rd=0` → result has `res_rd` = 0, `res_data` = 7. `dbg` x0 = 0. A following `rs1=0` op reads 0 (no forward).
  - Assert `reset` with EX and WB full → all outputs 0 next cycle, register file unchanged by the dropped ops.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand-issue (EX) and writeback (WB) stage around the
// combinational alu32. EX holds the registered ALU operands; WB holds the
// captured result until the downstream consumer takes it. A RAW dependence
// on the op sitting in EX is resolved by forwarding aluout (FWD_EN=1) or by
// holding off issue for one cycle (FWD_EN=0).
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int FWD_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    // decoded op in
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_useimm,
    input  logic [3:0]        in_alucontrol,
    input  logic [4:0]        in_shamt,
    // to / from alu32
    output logic [DATA_W-1:0] srca,
    output logic [DATA_W-1:0] srcb,
    output logic [3:0]        alucontrol,
    output logic [4:0]        shamt,
    input  logic [DATA_W-1:0] aluout,
    input  logic              zero,
    // result out
    output logic              res_valid,
    input  logic              res_ready,
    output logic [4:0]        res_rd,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    // display read port
    input  logic [4:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);

    logic              vld_p1;      // op present in EX
    logic              vld_p2;      // result present in WB
    logic [4:0]        rd_p1;       // destination of the op in EX
    logic [DATA_W-1:0] rf [32];     // entry 0 is never written

    logic              wb_free;
    logic              ex_adv;
    logic              haz_rs1;
    logic              haz_rs2;
    logic              hazard;
    logic              accept;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;

    // x0 is hard-wired to zero regardless of what the array holds
    function automatic logic [DATA_W-1:0] rf_read(input logic [4:0] idx);
        return (idx == 5'd0) ? {DATA_W{1'b0}} : rf[idx];
    endfunction

    assign wb_free = !vld_p2 || res_ready;
    assign ex_adv  = vld_p1 && wb_free;

    // Only the op in EX can be newer than the register file: WB results were
    // written to rf when they left EX. Destination x0 never creates a hazard.
    assign haz_rs1 = vld_p1 && (rd_p1 != 5'd0) && (rd_p1 == in_rs1);
    assign haz_rs2 = vld_p1 && (rd_p1 != 5'd0) && !in_useimm && (rd_p1 == in_rs2);
    assign hazard  = haz_rs1 || haz_rs2;

    assign in_ready = !reset && (!vld_p1 || ex_adv) && !((FWD_EN == 0) && hazard);
    assign accept   = in_valid && in_ready;

    // Operand select: forwarded EX result wins over the stale register file
    always_comb begin
        opa = rf_read(in_rs1);
        opb = rf_read(in_rs2);
        if ((FWD_EN != 0) && haz_rs1) begin
            opa = aluout;
        end
        if ((FWD_EN != 0) && haz_rs2) begin
            opb = aluout;
        end
        if (in_useimm) begin
            opb = in_imm;
        end
    end

    // ---- EX stage: load operands on accept, empty when the op moves to WB
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            rd_p1      <= 5'd0;
            srca       <= '0;
            srcb       <= '0;
            alucontrol <= 4'd0;
            shamt      <= 5'd0;
        end else if (accept) begin
            vld_p1     <= 1'b1;
            rd_p1      <= in_rd;
            srca       <= opa;
            srcb       <= opb;
            alucontrol <= in_alucontrol;
            shamt      <= in_shamt;
        end else if (ex_adv) begin
            vld_p1     <= 1'b0;
        end
    end

    // ---- WB stage: capture the ALU result, hold it until the consumer takes it
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2   <= 1'b0;
            res_rd   <= 5'd0;
            res_data <= '0;
            res_zero <= 1'b0;
        end else if (ex_adv) begin
            vld_p2   <= 1'b1;
            res_rd   <= rd_p1;
            res_data <= aluout;
            res_zero <= zero;
        end else if (res_ready) begin
            vld_p2   <= 1'b0;
        end
    end

    // Register file write on EX->WB advance; results for x0 are not stored
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (ex_adv && (rd_p1 != 5'd0)) begin
            rf[rd_p1] <= aluout;
        end
    end

    assign res_valid = vld_p2;
    assign dbg_rdata = rf_read(dbg_raddr);

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: two instances (forwarding and stalling) driven from one
// bench. A sequential-ISA model updates an architectural register file at
// accept time and queues the expected result; a monitor pops and compares
// whenever a result is handed downstream.
module tb_alu_issue_stage;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b1000;
    localparam logic [3:0] OP_SHL = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;

    logic        in_valid      [2];
    logic        in_ready      [2];
    logic [4:0]  in_rs1        [2];
    logic [4:0]  in_rs2        [2];
    logic [4:0]  in_rd         [2];
    logic [31:0] in_imm        [2];
    logic        in_useimm     [2];
    logic [3:0]  in_alucontrol [2];
    logic [4:0]  in_shamt      [2];
    logic [31:0] srca          [2];
    logic [31:0] srcb          [2];
    logic [3:0]  alucontrol    [2];
    logic [4:0]  shamt         [2];
    logic [31:0] aluout        [2];
    logic        zero          [2];
    logic        res_valid     [2];
    logic        res_ready     [2];
    logic [4:0]  res_rd        [2];
    logic [31:0] res_data      [2];
    logic        res_zero      [2];
    logic [4:0]  dbg_raddr     [2];
    logic [31:0] dbg_rdata     [2];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rr_mode = 0;          // 0: ready high, 1: random, 2: ready low
    logic [31:0] mrf [2][32];          // architectural register file model
    exp_t        q0[$];
    exp_t        q1[$];
    int          pop_cnt [2];
    int          pop_cyc [2][1024];
    logic [31:0] last_data [2];
    logic        last_zero [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural alu32 stand-in
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c, input logic [4:0] s);
        case (c)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SHL:  return b << s;
            default: return a ^ b;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_alu
        assign aluout[g] = alu_f(srca[g], srcb[g], alucontrol[g], shamt[g]);
        assign zero[g]   = (aluout[g] == 32'd0);
    end

    alu_issue_stage #(.DATA_W(32), .FWD_EN(1)) u_fwd (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_rs1(in_rs1[0]), .in_rs2(in_rs2[0]), .in_rd(in_rd[0]),
        .in_imm(in_imm[0]), .in_useimm(in_useimm[0]),
        .in_alucontrol(in_alucontrol[0]), .in_shamt(in_shamt[0]),
        .srca(srca[0]), .srcb(srcb[0]), .alucontrol(alucontrol[0]), .shamt(shamt[0]),
        .aluout(aluout[0]), .zero(zero[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]),
        .res_rd(res_rd[0]), .res_data(res_data[0]), .res_zero(res_zero[0]),
        .dbg_raddr(dbg_raddr[0]), .dbg_rdata(dbg_rdata[0])
    );

    alu_issue_stage #(.DATA_W(32), .FWD_EN(0)) u_stl (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_rs1(in_rs1[1]), .in_rs2(in_rs2[1]), .in_rd(in_rd[1]),
        .in_imm(in_imm[1]), .in_useimm(in_useimm[1]),
        .in_alucontrol(in_alucontrol[1]), .in_shamt(in_shamt[1]),
        .srca(srca[1]), .srcb(srcb[1]), .alucontrol(alucontrol[1]), .shamt(shamt[1]),
        .aluout(aluout[1]), .zero(zero[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]),
        .res_rd(res_rd[1]), .res_data(res_data[1]), .res_zero(res_zero[1]),
        .dbg_raddr(dbg_raddr[1]), .dbg_rdata(dbg_rdata[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void q_push(input int k, input exp_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic int q_size(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t q_pop(input int k);
        if (k == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 32; i++) mrf[k][i] = 32'd0;
        q0.delete();
        q1.delete();
    endfunction

    // Offer one op (call at a falling edge); returns cycles spent waiting.
    task automatic issue(input int k, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] imm, input logic useimm,
                         input logic [3:0] op, input logic [4:0] sh, output int waits);
        logic [31:0] a, b, r;
        exp_t e;
        in_valid[k] = 1'b1;  in_rs1[k] = rs1;  in_rs2[k] = rs2;  in_rd[k] = rd;
        in_imm[k] = imm;  in_useimm[k] = useimm;  in_alucontrol[k] = op;  in_shamt[k] = sh;
        waits = 0;
        #1;
        while (!in_ready[k] && waits < 200) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!in_ready[k]) begin
            chk("accept_timeout", {31'd0, in_ready[k]}, 32'd1);
            in_valid[k] = 1'b0;
            return;
        end
        a = (rs1 == 5'd0) ? 32'd0 : mrf[k][rs1];
        b = useimm ? imm : ((rs2 == 5'd0) ? 32'd0 : mrf[k][rs2]);
        r = alu_f(a, b, op, sh);
        if (rd != 5'd0) mrf[k][rd] = r;
        e.rd = rd;  e.data = r;  e.zero = (r == 32'd0);
        q_push(k, e);
        @(negedge clk);
        in_valid[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        while (q_size(k) != 0 && n < 300) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk("drain_timeout", q_size(k), 32'd0);
    endtask

    task automatic chk_rf(input int k, input int idx, input logic [31:0] exp, input string name);
        dbg_raddr[k] = 5'(idx);
        #1;
        chk(name, dbg_rdata[k], exp);
    endtask

    // Monitor: drives res_ready, and on every handshake pops and compares
    always begin : mon
        exp_t e;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            case (rr_mode)
                0:       res_ready[k] = 1'b1;
                1:       res_ready[k] = ($urandom_range(0, 1) == 1);
                default: res_ready[k] = 1'b0;
            endcase
        end
        #2;
        for (int k = 0; k < 2; k++) begin
            if (!reset && res_valid[k] && res_ready[k]) begin
                if (q_size(k) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: dut%0d rd=%0d data=0x%08h, want no result",
                             k, res_rd[k], res_data[k]);
                end else begin
                    e = q_pop(k);
                    chk("res_rd", {27'd0, res_rd[k]}, {27'd0, e.rd});
                    chk("res_data", res_data[k], e.data);
                    chk("res_zero", {31'd0, res_zero[k]}, {31'd0, e.zero});
                end
                last_data[k] = res_data[k];
                last_zero[k] = res_zero[k];
                if (pop_cnt[k] < 1024) pop_cyc[k][pop_cnt[k]] = cyc;
                pop_cnt[k]++;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, want finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int w;
        int pc;
        logic [4:0]  r1, r2, rd;
        logic [3:0]  op;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0;  in_rs1[k] = '0;  in_rs2[k] = '0;  in_rd[k] = '0;
            in_imm[k] = '0;  in_useimm[k] = 1'b0;  in_alucontrol[k] = '0;  in_shamt[k] = '0;
            dbg_raddr[k] = '0;  pop_cnt[k] = 0;  last_data[k] = '0;  last_zero[k] = 1'b0;
        end
        model_clear();

        // reset behaviour
        repeat (2) @(negedge clk);
        #1;
        chk("ready_in_reset0", {31'd0, in_ready[0]}, 32'd0);
        chk("ready_in_reset1", {31'd0, in_ready[1]}, 32'd0);
        chk("reset_res_valid", {31'd0, res_valid[0]}, 32'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset0", {31'd0, in_ready[0]}, 32'd1);
        chk("ready_after_reset1", {31'd0, in_ready[1]}, 32'd1);
        for (int i = 0; i < 32; i++) begin
            chk_rf(0, i, 32'd0, "rf_reset0");
            chk_rf(1, i, 32'd0, "rf_reset1");
        end
        @(negedge clk);

        // dependent chain with forwarding: no bubble
        issue(0, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1, OP_ADD, 5'd0, w);
        chk("fwd_first_wait", w, 32'd0);
        issue(0, 5'd1, 5'd1, 5'd2, 32'd0, 1'b0, OP_ADD, 5'd0, w);
        chk("fwd_dep_wait", w, 32'd0);
        drain(0);
        chk("fwd_back_to_back", pop_cyc[0][pop_cnt[0]-1] - pop_cyc[0][pop_cnt[0]-2], 32'd1);
        chk("fwd_last", last_data[0], 32'd10);
        @(negedge clk);
        chk_rf(0, 2, 32'd10, "fwd_x2");
        @(negedge clk);

        // same chain with stalling: one cycle of in_ready low
        issue(1, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1, OP_ADD, 5'd0, w);
        chk("stall_first_wait", w, 32'd0);
        issue(1, 5'd1, 5'd1, 5'd2, 32'd0, 1'b0, OP_ADD, 5'd0, w);
        chk("stall_dep_wait", w, 32'd1);
        drain(1);
        chk("stall_last", last_data[1], 32'd10);
        @(negedge clk);
        chk_rf(1, 2, 32'd10, "stall_x2");
        @(negedge clk);

        // subtract and zero flag
        issue(0, 5'd0, 5'd0, 5'd1, 32'd3, 1'b1, OP_ADD, 5'd0, w);
        issue(0, 5'd0, 5'd0, 5'd2, 32'd5, 1'b1, OP_ADD, 5'd0, w);
        issue(0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, OP_SUB, 5'd0, w);
        drain(0);
        chk("sub_neg_data", last_data[0], 32'hFFFF_FFFE);
        chk("sub_neg_zero", {31'd0, last_zero[0]}, 32'd0);
        issue(0, 5'd1, 5'd1, 5'd4, 32'd0, 1'b0, OP_SUB, 5'd0, w);
        drain(0);
        chk("sub_self_data", last_data[0], 32'd0);
        chk("sub_self_zero", {31'd0, last_zero[0]}, 32'd1);

        // backpressure: WB and EX fill, then issue blocks
        rr_mode = 2;
        @(negedge clk);
        #1;
        pc = pop_cnt[0];
        issue(0, 5'd0, 5'd0, 5'd5, 32'd1, 1'b1, OP_ADD, 5'd0, w);
        chk("bp_op1_wait", w, 32'd0);
        issue(0, 5'd0, 5'd0, 5'd6, 32'd2, 1'b1, OP_ADD, 5'd0, w);
        chk("bp_op2_wait", w, 32'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready_low", {31'd0, in_ready[0]}, 32'd0);
            chk("bp_hold_data", res_data[0], 32'd1);
            @(negedge clk);
        end
        #1;
        rr_mode = 0;
        issue(0, 5'd0, 5'd0, 5'd7, 32'd3, 1'b1, OP_ADD, 5'd0, w);
        drain(0);
        chk("bp_count", pop_cnt[0] - pc, 32'd3);
        chk("bp_last", last_data[0], 32'd3);

        // x0 destination and rs1=0 never forwarded
        issue(0, 5'd0, 5'd0, 5'd0, 32'd7, 1'b1, OP_ADD, 5'd0, w);
        issue(0, 5'd0, 5'd0, 5'd8, 32'd1, 1'b1, OP_ADD, 5'd0, w);
        drain(0);
        chk("x0_follow", last_data[0], 32'd1);
        @(negedge clk);
        chk_rf(0, 0, 32'd0, "x0_rf");
        chk_rf(0, 8, 32'd1, "x8_rf");
        @(negedge clk);

        // randomized traffic with random backpressure on both instances
        rr_mode = 1;
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 150; n++) begin
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                r1 = 5'($urandom_range(0, 7));
                r2 = 5'($urandom_range(0, 7));
                rd = 5'($urandom_range(0, 7));
                case ($urandom_range(0, 3))
                    0:       op = OP_ADD;
                    1:       op = OP_SUB;
                    2:       op = OP_SHL;
                    default: op = OP_XOR;
                endcase
                issue(k, r1, r2, rd, $urandom, ($urandom_range(0, 2) == 0), op,
                      5'($urandom_range(0, 31)), w);
            end
            drain(k);
            @(negedge clk);
            for (int i = 0; i < 8; i++) chk_rf(k, i, mrf[k][i], "rand_rf");
            @(negedge clk);
        end
        rr_mode = 0;
        @(negedge clk);

        // reset with EX and WB both occupied
        rr_mode = 2;
        @(negedge clk);
        #1;
        issue(0, 5'd0, 5'd0, 5'd9, 32'h55, 1'b1, OP_ADD, 5'd0, w);
        issue(0, 5'd0, 5'd0, 5'd10, 32'h66, 1'b1, OP_SHL, 5'd3, w);
        #1;
        chk("mid_pre_valid", {31'd0, res_valid[0]}, 32'd1);
        reset = 1'b1;
        model_clear();
        pc = pop_cnt[0];
        @(negedge clk);
        #1;
        chk("mid_srca", srca[0], 32'd0);
        chk("mid_srcb", srcb[0], 32'd0);
        chk("mid_alucontrol", {28'd0, alucontrol[0]}, 32'd0);
        chk("mid_shamt", {27'd0, shamt[0]}, 32'd0);
        chk("mid_res_valid", {31'd0, res_valid[0]}, 32'd0);
        chk("mid_res_rd", {27'd0, res_rd[0]}, 32'd0);
        chk("mid_res_data", res_data[0], 32'd0);
        chk("mid_res_zero", {31'd0, res_zero[0]}, 32'd0);
        chk("mid_ready", {31'd0, in_ready[0]}, 32'd0);
        reset = 1'b0;
        rr_mode = 0;
        chk_rf(0, 9, 32'd0, "mid_x9");
        chk_rf(0, 10, 32'd0, "mid_x10");
        repeat (4) @(negedge clk);
        #3;
        chk("mid_no_results", pop_cnt[0] - pc, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
